// File: rtl/sec_counter_bcd_pkg.sv
// Shared types for the seconds counter / seven-segment display chain.
// State encodings, BCD digit width and the BCD increment helper.
package sec_counter_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int BCD_W      = 4;
    localparam int DEF_CLK_HZ = 50_000_000;

    function automatic logic [2*BCD_W-1:0] bcd_inc(
        input logic [2*BCD_W-1:0] v,
        input logic [2*BCD_W-1:0] last
    );
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
        tens  = v[2*BCD_W-1:BCD_W];
        units = v[BCD_W-1:0];
        if (v == last) begin
            return '0;
        end
        if (units == BCD_W'(9)) begin
            units = '0;
            tens  = (tens == BCD_W'(9)) ? '0 : tens + 1'b1;
        end else begin
            units = units + 1'b1;
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/sec_counter_bcd_key_debounce.sv
// Push-button front end: 2-flop sync, stability debounce, press pulse.
// A key held through reset must be released before it can pulse again.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic          armed;
    logic [1:0]    fill;
    logic [CW-1:0] cnt;
    logic          pressed_raw;

    assign pressed_raw = ~sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b0;
            level_d <= 1'b0;
            armed   <= 1'b0;
            fill    <= 2'b00;
            cnt     <= '0;
        end else begin
            sync1   <= key;
            sync2   <= sync1;
            level_d <= level;
            fill    <= {fill[0], 1'b1};
            // sync2 is only a real key sample once fill[1] is set
            if (fill[1] && sync2) begin
                armed <= 1'b1;
            end
            if (pressed_raw != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= pressed_raw;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_d & armed;

endmodule

// File: rtl/sec_counter_bcd.sv
// Two-digit BCD seconds counter with start/stop and clear keys.
// Holds the run/pause FSM, the one-second prescaler and the BCD count.
module sec_counter_bcd
    import sec_counter_bcd_pkg::*;
#(
    parameter int         CLK_HZ          = DEF_CLK_HZ,
    parameter int         DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [7:0] WRAP_BCD        = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_stop,
    input  logic       key_clear,
    output logic [7:0] value,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    localparam int PW = $clog2(CLK_HZ);

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic          ss_press;
    logic          clr_press;
    logic          incr;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_ss (
        .clk  (clk),
        .rst  (rst),
        .key  (key_start_stop),
        .press(ss_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_clr (
        .clk  (clk),
        .rst  (rst),
        .key  (key_clear),
        .press(clr_press)
    );

    always_comb begin
        state_d = state_q;
        incr    = (state_q == RUN)
               && (presc_q == PW'(CLK_HZ - 1))
               && !clr_press;
        unique case (1'b1)
            clr_press:              state_d = IDLE;
            ss_press && !clr_press: state_d = (state_q == RUN) ? PAUSE : RUN;
            default:                ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            value   <= 8'h00;
            running <= 1'b0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= (state_d == RUN);
            tick    <= incr;
            wrap    <= incr && (value == WRAP_BCD);
            // PAUSE leaves the prescaler alone to keep the partial second
            if (clr_press || state_q == IDLE) begin
                presc_q <= '0;
            end else if (state_q == RUN) begin
                presc_q <= incr ? '0 : presc_q + 1'b1;
            end
            if (clr_press) begin
                value <= 8'h00;
            end else if (incr) begin
                value <= bcd_inc(value, WRAP_BCD);
            end
        end
    end

endmodule
